pipe_mdu: RTL and testbench

PIPE_MDU -- requirements
Module: pipe_mdu

---
 rtl/pipe_mdu.sv | 156 +++++++++++++++
 tb/tb_pipe_mdu.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_mdu.sv
// Multi-cycle MIPS-style multiply/divide unit with HI/LO registers.
// Optional macro PIPE_MDU_FAST_MULT_EN makes mult/multu single-cycle.
module pipe_mdu (
    input  logic        clk,
    input  logic        clrn,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        mthi,
    input  logic        mtlo,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t      r_state;
    logic [5:0]  r_count;
    logic        r_signed;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_accHi;
    logic [31:0] r_accLo;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;

    logic        w_signed;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic        w_negQ;
    logic        w_negR;
    logic [32:0] w_mulSum;
    logic [31:0] w_mulHi;
    logic [31:0] w_mulLo;
    logic [63:0] w_prod;
    logic [63:0] w_prodRes;
    logic [32:0] w_divShift;
    logic [32:0] w_divDiff;
    logic        w_divOk;
    logic [31:0] w_divHi;
    logic [31:0] w_divLo;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = ~op[0];
    assign w_magA   = (w_signed && a[31]) ? (32'd0 - a) : a;

    // Operand signs and divisor magnitude come from the latched copies only.
    assign w_magB = (r_signed && r_b[31]) ? (32'd0 - r_b) : r_b;
    assign w_negQ = r_signed & (r_a[31] ^ r_b[31]);
    assign w_negR = r_signed & r_a[31];

    // Shift-add step: accumulate into the upper half, retire one multiplier bit.
    assign w_mulSum  = {1'b0, r_accHi} + (r_accLo[0] ? {1'b0, w_magB} : 33'd0);
    assign w_mulHi   = w_mulSum[32:1];
    assign w_mulLo   = {w_mulSum[0], r_accLo[31:1]};
    assign w_prod    = {w_mulHi, w_mulLo};
    assign w_prodRes = w_negQ ? (64'd0 - w_prod) : w_prod;

    // Restoring step: the partial remainder stays below the divisor, so 32 bits hold it.
    assign w_divShift = {r_accHi, r_accLo[31]};
    assign w_divDiff  = w_divShift - {1'b0, w_magB};
    assign w_divOk    = ~w_divDiff[32];
    assign w_divHi    = w_divOk ? w_divDiff[31:0] : w_divShift[31:0];
    assign w_divLo    = {r_accLo[30:0], w_divOk};
    assign w_quo      = w_negQ ? (32'd0 - w_divLo) : w_divLo;
    assign w_rem      = w_negR ? (32'd0 - w_divHi) : w_divHi;

`ifdef PIPE_MDU_FAST_MULT_EN
    logic [63:0] w_fastProd;
    assign w_fastProd = op[0] ? ({32'd0, a} * {32'd0, b})
                              : ({{32{a[31]}}, a} * {{32{b[31]}}, b});
`endif

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state  <= IDLE;
            r_count  <= 6'd0;
            r_signed <= 1'b0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_accHi  <= 32'd0;
            r_accLo  <= 32'd0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_signed <= w_signed;
                        r_a      <= a;
                        r_b      <= b;
                        r_accHi  <= 32'd0;
                        r_accLo  <= w_magA;
`ifdef PIPE_MDU_FAST_MULT_EN
                        if (!op[1]) begin
                            {r_hi, r_lo} <= w_fastProd;
                            r_done       <= 1'b1;
                        end else begin
                            r_count <= 6'd32;
                            r_state <= DIV;
                        end
`else
                        r_count <= 6'd32;
                        r_state <= op[1] ? DIV : MUL;
`endif
                    end else begin
                        if (mthi) r_hi <= wdata;
                        if (mtlo) r_lo <= wdata;
                    end
                end
                MUL: begin
                    r_accHi <= w_mulHi;
                    r_accLo <= w_mulLo;
                    r_count <= r_count - 6'd1;
                    if (r_count == 6'd1) begin
                        {r_hi, r_lo} <= w_prodRes;
                        r_done       <= 1'b1;
                        r_state      <= IDLE;
                    end
                end
                DIV: begin
                    r_accHi <= w_divHi;
                    r_accLo <= w_divLo;
                    r_count <= r_count - 6'd1;
                    if (r_count == 6'd1) begin
                        // Divide by zero reports all-ones quotient and the raw dividend.
                        if (w_magB == 32'd0) begin
                            r_hi <= r_a;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quo;
                        end
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy = (r_state == MUL) || (r_state == DIV);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_pipe_mdu.sv
// Scoreboard bench for pipe_mdu: a driver queues expected HI/LO and completion
// cycle per operation, a monitor pops and compares on every done pulse.
module tb_pipe_mdu;

    logic        clk = 1'b0;
    logic        clrn;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    pipe_mdu dut (
        .clk   (clk),
        .clrn  (clrn),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

`ifdef PIPE_MDU_FAST_MULT_EN
    localparam bit FastMult = 1'b1;
`else
    localparam bit FastMult = 1'b0;
`endif

    typedef struct {
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expCycle;
        string       tag;
    } exp_t;

    exp_t        sbQ[$];
    int          cycleCnt = 0;
    int          nVectors = 0;
    int          nFails = 0;
    logic [31:0] modelHi = 32'd0;
    logic [31:0] modelLo = 32'd0;
    logic [31:0] prevHi = 32'd0;
    logic [31:0] prevLo = 32'd0;

    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Reference results straight from the arithmetic definitions.
    function automatic void refModel(input logic [1:0] o, input logic [31:0] x,
                                     input logic [31:0] y,
                                     output logic [31:0] rh, output logic [31:0] rl);
        longint          sx, sy, sq, sr;
        longint unsigned ux, uy;
        logic [63:0]     p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'd0, x};
        uy = {32'd0, y};
        case (o)
            2'd0: p = 64'(sx * sy);
            2'd1: p = 64'(ux * uy);
            2'd2: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    p  = {32'(sr), 32'(sq)};
                end
            end
            default: begin
                if (y == 32'd0) p = {x, 32'hFFFF_FFFF};
                else p = {32'(ux % uy), 32'(ux / uy)};
            end
        endcase
        rh = p[63:32];
        rl = p[31:0];
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cycleCnt);
        end
    endtask

    // Issues one operation at a negedge while idle; returns one cycle later.
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] x,
                                 input logic [31:0] y, input string tag,
                                 input logic setHi, input logic setLo,
                                 input logic [31:0] wd);
        exp_t        e;
        logic [31:0] rh, rl;
        int          lat;
        logic        expBusy;
        refModel(o, x, y, rh, rl);
        lat     = (!o[1] && FastMult) ? 0 : 32;
        expBusy = (lat != 0);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        mthi  = setHi;
        mtlo  = setLo;
        wdata = wd;
        e.expHi    = rh;
        e.expLo    = rl;
        e.expCycle = cycleCnt + 1 + lat;
        e.tag      = tag;
        sbQ.push_back(e);
        prevHi  = modelHi;
        prevLo  = modelLo;
        modelHi = rh;
        modelLo = rl;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        checkOutput({tag, "_busy"}, 32'(busy), 32'(expBusy));
    endtask

    task automatic waitIdle();
        int k = 0;
        while ((sbQ.size() != 0 || busy) && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (k >= 200) begin
            nVectors++;
            nFails++;
            $display("[TB] FAIL idleTimeout: pending %0d, busy %0b", sbQ.size(), busy);
            sbQ.delete();
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedDone", 32'(done), 32'd0);
                end else begin
                    e = sbQ.pop_front();
                    checkOutput({e.tag, "_hi"}, hi, e.expHi);
                    checkOutput({e.tag, "_lo"}, lo, e.expLo);
                    checkOutput({e.tag, "_cycle"}, 32'(cycleCnt), 32'(e.expCycle));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx, ry;
        int          dc;
        clrn  = 1'b0;
        start = 1'b0;
        op    = 2'd0;
        a     = 32'd0;
        b     = 32'd0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = 32'd0;
        repeat (2) @(negedge clk);
        checkOutput("resetHi", hi, 32'd0);
        checkOutput("resetLo", lo, 32'd0);
        checkOutput("resetBusy", 32'(busy), 32'd0);
        checkOutput("resetDone", 32'(done), 32'd0);
        clrn = 1'b1;
        @(negedge clk);

        applyStimulus(2'd0, 32'hFFFF_FFFE, 32'd3, "multNeg2x3", 1'b0, 1'b0, 32'd0);
        waitIdle();
        applyStimulus(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multuMax", 1'b0, 1'b0, 32'd0);
        waitIdle();
        applyStimulus(2'd2, 32'hFFFF_FFF9, 32'd2, "divNeg7by2", 1'b0, 1'b0, 32'd0);
        waitIdle();
        applyStimulus(2'd3, 32'd7, 32'd0, "divuBy0", 1'b0, 1'b0, 32'd0);
        waitIdle();
        applyStimulus(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "divOverflow", 1'b0, 1'b0, 32'd0);
        waitIdle();
        applyStimulus(2'd2, 32'd1234, 32'd0, "divBy0", 1'b0, 1'b0, 32'd0);
        waitIdle();

        // A second start in the middle of a divide must be dropped entirely.
        applyStimulus(2'd2, 32'hFFFF_F000, 32'd37, "divIgnore", 1'b0, 1'b0, 32'd0);
        repeat (8) @(negedge clk);
        start = 1'b1;
        op    = 2'd3;
        a     = 32'd100;
        b     = 32'd7;
        @(negedge clk);
        start = 1'b0;
        checkOutput("holdHiDuringDiv", hi, prevHi);
        checkOutput("holdLoDuringDiv", lo, prevLo);
        waitIdle();
        repeat (5) @(negedge clk);
        checkOutput("ignoredStartNotRun", 32'(busy), 32'd0);

        // Direct HI/LO writes while idle.
        mthi  = 1'b1;
        wdata = 32'hA5A5_0001;
        @(negedge clk);
        mthi    = 1'b0;
        modelHi = 32'hA5A5_0001;
        checkOutput("mthiIdle", hi, modelHi);
        checkOutput("mthiNoDone", 32'(done), 32'd0);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h0BAD_F00D;
        @(negedge clk);
        mthi    = 1'b0;
        mtlo    = 1'b0;
        modelHi = 32'h0BAD_F00D;
        modelLo = 32'h0BAD_F00D;
        checkOutput("mthiBoth", hi, modelHi);
        checkOutput("mtloBoth", lo, modelLo);

        applyStimulus(2'd0, 32'd5, 32'd9, "startBeatsMthi", 1'b1, 1'b0, 32'h1234_5678);
        waitIdle();

        applyStimulus(2'd3, 32'd1000, 32'd3, "divuMtlo", 1'b0, 1'b0, 32'd0);
        repeat (4) @(negedge clk);
        mtlo  = 1'b1;
        wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        mtlo = 1'b0;
        checkOutput("loHoldMtlo", lo, prevLo);
        waitIdle();

        // Reset mid-operation discards the result and clears everything at once.
        applyStimulus(FastMult ? 2'd2 : 2'd0, 32'h0012_3456, 32'd789, "abort", 1'b0, 1'b0, 32'd0);
        repeat (14) @(negedge clk);
        clrn = 1'b0;
        #1;
        checkOutput("abortBusy", 32'(busy), 32'd0);
        checkOutput("abortHi", hi, 32'd0);
        checkOutput("abortLo", lo, 32'd0);
        sbQ.delete();
        modelHi = 32'd0;
        modelLo = 32'd0;
        @(negedge clk);
        clrn = 1'b1;
        dc = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dc++;
        end
        checkOutput("abortNoDone", 32'(dc), 32'd0);
        applyStimulus(2'd0, 32'd6, 32'd7, "mult6x7", 1'b0, 1'b0, 32'd0);
        waitIdle();

        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = $urandom;
            if ($urandom_range(0, 7) == 0) ry = 32'd0;
            else if ($urandom_range(0, 3) == 0) ry = 32'($urandom_range(1, 20));
            applyStimulus(ro, rx, ry, $sformatf("rand%0d_op%0d", i, ro), 1'b0, 1'b0, 32'd0);
            waitIdle();
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFails);
        $finish;
    end

endmodule
